box_overlay: RTL and testbench

Parametrised multi-box overlay engine that replaces the single hard-wired box generator in the HDMI top level. It holds NUM_BOXES movable rectangles, moves the currently selected one once per frame from debounced button inputs with screen-edge clamping, and produces registered 8-bit R/G/B per pixel. Sync and blanking are delayed to stay aligned with the colour outputs. It sits between `video_sync` and the three `parallel_to_serial` TMDS channels, all in the pixel/data clock domain.

---
 rtl/box_overlay_if.sv | 38 +++
 rtl/box_overlay.sv | 200 ++++++++++++++++++++
 tb/tb_box_overlay.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/box_overlay_if.sv
// Video-path and button bundle between the timing source and the box overlay engine.
// Latency: none, this is plain wiring.
// Backpressure: none; pixels stream at one per clock with no ready signal.
interface box_overlay_if #(
    parameter int COORD_W = 10
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               blanking_in;
    logic               hsync_in;
    logic               vsync_in;
    logic               btn_right;
    logic               btn_left;
    logic               btn_up;
    logic               btn_down;
    logic               btn_sel;
    logic [7:0]         red;
    logic [7:0]         green;
    logic [7:0]         blue;
    logic               blanking_out;
    logic               hsync_out;
    logic               vsync_out;
    logic [2:0]         sel_idx;

    // Video source and buttons side.
    modport master (
        output x, y, blanking_in, hsync_in, vsync_in,
        output btn_right, btn_left, btn_up, btn_down, btn_sel,
        input  red, green, blue, blanking_out, hsync_out, vsync_out, sel_idx
    );

    // Overlay engine side.
    modport slave (
        input  x, y, blanking_in, hsync_in, vsync_in,
        input  btn_right, btn_left, btn_up, btn_down, btn_sel,
        output red, green, blue, blanking_out, hsync_out, vsync_out, sel_idx
    );
endinterface

// File: rtl/box_overlay.sv
// Multi-box overlay: NUM_BOXES movable rectangles drawn over a flat background.
// Latency: 2 clk from x/y/blanking/sync to RGB and delayed syncs.
// Backpressure: none; one pixel per clock, always accepted.
module box_overlay #(
    parameter int                      NUM_BOXES = 4,
    parameter int                      COORD_W   = 10,
    parameter int                      H_ACTIVE  = 640,
    parameter int                      V_ACTIVE  = 480,
    parameter int                      BOX_W     = 100,
    parameter int                      BOX_H     = 100,
    parameter int                      STEP      = 1,
    parameter int                      INIT_X    = 20,
    parameter int                      INIT_Y    = 100,
    parameter int                      SPACING   = 150,
    parameter logic [24*NUM_BOXES-1:0] PALETTE   = 96'hFF7F00_00FF00_0000FF_FFFF00,
    parameter logic [23:0]             BG_COLOR  = 24'h505050
) (
    input  logic         clk,
    input  logic         rst,
    box_overlay_if.slave bus
);
    localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] X_MAX  = (COORD_W+1)'(H_ACTIVE - BOX_W);
    localparam logic [COORD_W:0] Y_MAX  = (COORD_W+1)'(V_ACTIVE - BOX_H);
    localparam logic [COORD_W:0] BW     = (COORD_W+1)'(BOX_W);
    localparam logic [COORD_W:0] BH     = (COORD_W+1)'(BOX_H);
    localparam logic [COORD_W:0] BW_M1  = (COORD_W+1)'(BOX_W - 1);
    localparam logic [COORD_W:0] BH_M1  = (COORD_W+1)'(BOX_H - 1);

    // Button bit order: {sel, down, up, left, right}.
    logic [4:0]         btn_raw;
    logic [4:0]         btn_s1_q;
    logic [4:0]         btn_s2_q;
    logic               vs_prev_q;
    logic               vs_armed_q;
    logic               frame_tick;

    logic [COORD_W-1:0] bx_q [NUM_BOXES];
    logic [COORD_W-1:0] bx_d [NUM_BOXES];
    logic [COORD_W-1:0] by_q [NUM_BOXES];
    logic [COORD_W-1:0] by_d [NUM_BOXES];
    logic [2:0]         sel_q, sel_d;
    logic               sel_prev_q, sel_prev_d;
    logic [COORD_W:0]   cx, cy, nx, ny;

    logic [NUM_BOXES-1:0] hit_d, hit_q, edge_d, edge_q;
    logic               blank1_q, hs1_q, vs1_q;
    logic [23:0]        rgb_d, rgb_q;
    logic               blank2_q, hs2_q, vs2_q;

    assign btn_raw = {bus.btn_sel, bus.btn_down, bus.btn_up, bus.btn_left, bus.btn_right};

    // A tick needs vsync to have been seen low since reset, so a release
    // during vsync waits for the next genuine rising edge.
    assign frame_tick = bus.vsync_in & ~vs_prev_q & vs_armed_q;

    function automatic logic in_span(input logic [COORD_W-1:0] p,
                                     input logic [COORD_W-1:0] s,
                                     input logic [COORD_W:0]   len);
        return ({1'b0, p} >= {1'b0, s}) && ({1'b0, p} < ({1'b0, s} + len));
    endfunction

    function automatic logic on_border(input logic [COORD_W-1:0] p,
                                       input logic [COORD_W-1:0] s,
                                       input logic [COORD_W:0]   len_m1);
        return (p == s) || ({1'b0, p} == ({1'b0, s} + len_m1));
    endfunction

    // Two-flop button synchroniser plus vsync edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            vs_prev_q  <= 1'b0;
            vs_armed_q <= 1'b0;
        end else begin
            btn_s1_q   <= btn_raw;
            btn_s2_q   <= btn_s1_q;
            vs_prev_q  <= bus.vsync_in;
            vs_armed_q <= vs_armed_q | ~bus.vsync_in;
        end
    end

    // Per-frame move of the selected box (right > left > up > down) and selection advance.
    always_comb begin
        bx_d       = bx_q;
        by_d       = by_q;
        sel_d      = sel_q;
        sel_prev_d = sel_prev_q;
        cx         = '0;
        cy         = '0;
        nx         = '0;
        ny         = '0;
        if (frame_tick) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                if (sel_q == 3'(i)) begin
                    cx = {1'b0, bx_q[i]};
                    cy = {1'b0, by_q[i]};
                    if (btn_s2_q[0]) begin
                        nx = cx + STEP_W;
                        if (nx > X_MAX) nx = X_MAX;
                        bx_d[i] = nx[COORD_W-1:0];
                    end else if (btn_s2_q[1]) begin
                        nx = (cx < STEP_W) ? '0 : cx - STEP_W;
                        bx_d[i] = nx[COORD_W-1:0];
                    end else if (btn_s2_q[2]) begin
                        ny = (cy < STEP_W) ? '0 : cy - STEP_W;
                        by_d[i] = ny[COORD_W-1:0];
                    end else if (btn_s2_q[3]) begin
                        ny = cy + STEP_W;
                        if (ny > Y_MAX) ny = Y_MAX;
                        by_d[i] = ny[COORD_W-1:0];
                    end
                end
            end
            // Move above used the old index; the new one applies from the next tick.
            sel_prev_d = btn_s2_q[4];
            if (btn_s2_q[4] && !sel_prev_q)
                sel_d = (sel_q == 3'(NUM_BOXES - 1)) ? 3'd0 : sel_q + 3'd1;
        end
    end

    // Box positions and selection state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BOXES; i++) begin
                bx_q[i] <= COORD_W'(INIT_X + i * SPACING);
                by_q[i] <= COORD_W'(INIT_Y);
            end
            sel_q      <= 3'd0;
            sel_prev_q <= 1'b0;
        end else begin
            bx_q       <= bx_d;
            by_q       <= by_d;
            sel_q      <= sel_d;
            sel_prev_q <= sel_prev_d;
        end
    end

    // Per-box coverage and border flags for the incoming pixel.
    always_comb begin
        hit_d  = '0;
        edge_d = '0;
        for (int i = 0; i < NUM_BOXES; i++) begin
            hit_d[i]  = in_span(bus.x, bx_q[i], BW) && in_span(bus.y, by_q[i], BH);
            edge_d[i] = hit_d[i] && (on_border(bus.x, bx_q[i], BW_M1) ||
                                     on_border(bus.y, by_q[i], BH_M1));
        end
    end

    // Stage 1: flags and syncs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q    <= '0;
            edge_q   <= '0;
            blank1_q <= 1'b1;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
        end else begin
            hit_q    <= hit_d;
            edge_q   <= edge_d;
            blank1_q <= bus.blanking_in;
            hs1_q    <= bus.hsync_in;
            vs1_q    <= bus.vsync_in;
        end
    end

    // Colour resolve: scan from the top index down so the lowest covering box wins.
    always_comb begin
        rgb_d = BG_COLOR;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            if (hit_q[i])
                rgb_d = (edge_q[i] && (sel_q == 3'(i))) ? 24'hFFFFFF : PALETTE[24*i +: 24];
        end
        if (blank1_q) rgb_d = '0;
    end

    // Stage 2: colour and aligned syncs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q    <= '0;
            blank2_q <= 1'b1;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            blank2_q <= blank1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
        end
    end

    assign bus.red          = rgb_q[23:16];
    assign bus.green        = rgb_q[15:8];
    assign bus.blue         = rgb_q[7:0];
    assign bus.blanking_out = blank2_q;
    assign bus.hsync_out    = hs2_q;
    assign bus.vsync_out    = vs2_q;
    assign bus.sel_idx      = sel_q;
endmodule

// File: tb/tb_box_overlay.sv
// Bench for box_overlay: box 0 = FF7F00, box 1 = 00FF00, box 2 = 0000FF, box 3 = FFFF00.
module tb_box_overlay;
    localparam logic [23:0] WH = 24'hFFFFFF;
    localparam logic [23:0] BG = 24'h505050;
    localparam logic [23:0] C0 = 24'hFF7F00;
    localparam logic [23:0] C1 = 24'h00FF00;
    localparam logic [23:0] C3 = 24'hFFFF00;
    localparam logic [29:0] RST_VEC = {24'h0, 3'b100, 3'd0};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    box_overlay_if #(.COORD_W(10)) vif();

    box_overlay #(
        .PALETTE(96'hFFFF00_0000FF_00FF00_FF7F00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct {
        int          due;
        string       name;
        logic [29:0] exp;
    } ent_t;

    ent_t sb[$];
    ent_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [29:0] act();
        return {vif.red, vif.green, vif.blue, vif.blanking_out, vif.hsync_out,
                vif.vsync_out, vif.sel_idx};
    endfunction

    task automatic check(input string name, input logic [29:0] a, input logic [29:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got rgb=%h bl/hs/vs=%b sel=%0d, expected rgb=%h bl/hs/vs=%b sel=%0d",
                     name, a[29:6], a[5:3], a[2:0], e[29:6], e[5:3], e[2:0]);
        end
    endtask

    // Monitor: pops every expectation whose output cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check(mon_e.name, act(), mon_e.exp);
        end
    end

    task automatic push(input string name, input logic [29:0] e);
        ent_t n;
        n.due  = cyc + 2;
        n.name = name;
        n.exp  = e;
        sb.push_back(n);
    endtask

    // Drive one pixel; when chk is set, queue the response due two cycles later.
    task automatic px(input int xx, input int yy, input bit bl, input bit hs, input bit vs,
                      input bit chk, input logic [23:0] rgb, input logic [2:0] sel,
                      input string name);
        logic [31:0] xv, yv;
        @(negedge clk);
        xv = xx;
        yv = yy;
        vif.x           = xv[9:0];
        vif.y           = yv[9:0];
        vif.blanking_in = bl;
        vif.hsync_in    = hs;
        vif.vsync_in    = vs;
        if (chk) push(name, {rgb, bl, hs, vs, sel});
    endtask

    task automatic chk_px(input int xx, input int yy, input logic [23:0] rgb,
                          input logic [2:0] sel, input string name);
        px(xx, yy, 1'b0, 1'b0, 1'b0, 1'b1, rgb, sel, name);
    endtask

    // One frame: buttons {sel,down,up,left,right} set well before the vsync rising edge.
    task automatic frame(input logic [4:0] btn);
        {vif.btn_sel, vif.btn_down, vif.btn_up, vif.btn_left, vif.btn_right} = btn;
        repeat (3) px(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 3'd0, "");
        repeat (2) px(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 3'd0, "");
        px(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 3'd0, "");
    endtask

    task automatic frames(input int n, input logic [4:0] btn);
        repeat (n) frame(btn);
    endtask

    initial begin
        logic [23:0] e;
        int          w;
        vif.x = '0; vif.y = '0;
        vif.blanking_in = 1'b1; vif.hsync_in = 1'b0; vif.vsync_in = 1'b0;
        {vif.btn_sel, vif.btn_down, vif.btn_up, vif.btn_left, vif.btn_right} = 5'b0;

        // Reset held: outputs pinned regardless of inputs.
        px(21, 101, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 3'd0, "");
        push("reset_hold_a", RST_VEC);
        px(20, 100, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 3'd0, "");
        push("reset_hold_b", RST_VEC);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Initial layout, box 0 selected.
        chk_px(20, 100, WH, 3'd0, "b0_corner_white");
        chk_px(21, 101, C0, 3'd0, "b0_interior");
        chk_px(19, 101, BG, 3'd0, "left_of_b0");
        chk_px(119, 101, WH, 3'd0, "b0_right_edge");
        chk_px(120, 101, BG, 3'd0, "b0_x_exclusive_end");
        chk_px(21, 199, WH, 3'd0, "b0_bottom_edge");
        chk_px(21, 200, BG, 3'd0, "b0_y_exclusive_end");
        chk_px(170, 101, C1, 3'd0, "b1_edge_unselected");
        chk_px(470, 101, C3, 3'd0, "b3_edge_unselected");
        px(50, 150, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 3'd0, "blank_inside_b0");
        chk_px(50, 150, C0, 3'd0, "unblank_inside_b0");

        // Line sweep at y=150 with an hsync pulse over x=180..189.
        for (int x = 0; x < 200; x++) begin
            if (x < 20)       e = BG;
            else if (x == 20) e = WH;
            else if (x < 119) e = C0;
            else if (x == 119) e = WH;
            else if (x < 170) e = BG;
            else              e = C1;
            px(x, 150, 1'b0, (x >= 180 && x < 190), 1'b0, 1'b1, e, 3'd0, "sweep_y150");
        end

        // Clamp at the right screen edge: 640-100 = 540.
        frames(600, 5'b00001);
        chk_px(540, 150, WH, 3'd0, "clamp_left_edge");
        chk_px(539, 150, C3, 3'd0, "clamp_left_of_b0");
        chk_px(541, 150, C0, 3'd0, "clamp_interior");
        chk_px(639, 150, WH, 3'd0, "clamp_right_edge");

        // 30 frames left: 510.
        frames(30, 5'b00010);
        chk_px(510, 150, WH, 3'd0, "left30_edge");
        chk_px(509, 150, C3, 3'd0, "left30_outside");
        chk_px(609, 150, WH, 3'd0, "left30_right_edge");
        chk_px(610, 150, BG, 3'd0, "left30_past_end");

        // Right and up together: only x moves, to 515.
        frames(5, 5'b00101);
        chk_px(515, 101, WH, 3'd0, "ru_new_left_edge");
        chk_px(514, 101, C3, 3'd0, "ru_left_of_b0");
        chk_px(516, 101, C0, 3'd0, "ru_interior");
        chk_px(516, 100, WH, 3'd0, "ru_top_unchanged");
        chk_px(516, 99, BG, 3'd0, "ru_above_b0");

        // Selection pulses spanning 1, 2, 3 and 4 ticks.
        frame(5'b00000);
        frames(1, 5'b10000); frame(5'b00000);
        chk_px(0, 0, BG, 3'd1, "sel_pulse1");
        frames(2, 5'b10000); frame(5'b00000);
        chk_px(0, 0, BG, 3'd2, "sel_pulse2");
        frames(3, 5'b10000); frame(5'b00000);
        chk_px(0, 0, BG, 3'd3, "sel_pulse3");
        frames(4, 5'b10000); frame(5'b00000);
        chk_px(0, 0, BG, 3'd0, "sel_wrap");
        frames(10, 5'b10000); frame(5'b00000);
        chk_px(0, 0, BG, 3'd1, "sel_hold10");
        chk_px(515, 150, C0, 3'd1, "b0_edge_deselected");

        // Box 1 right by 260 to x=430, overlapping box 0 at 515.
        frames(260, 5'b00001);
        chk_px(520, 150, C0, 3'd1, "overlap_b0_wins");
        chk_px(529, 150, C0, 3'd1, "overlap_b0_over_b1_edge");
        chk_px(430, 150, WH, 3'd1, "b1_selected_edge");
        chk_px(429, 150, BG, 3'd1, "left_of_b1");
        chk_px(470, 150, C1, 3'd1, "b1_over_b3");

        // Select and move on the same tick: box 1 moves, selection becomes 2.
        frame(5'b10001);
        chk_px(431, 150, C1, 3'd2, "samtick_b1_moved");
        chk_px(430, 150, BG, 3'd2, "samtick_b1_old_edge");
        frame(5'b00001);
        chk_px(321, 150, WH, 3'd2, "b2_moved_after_sel");
        chk_px(320, 150, BG, 3'd2, "b2_old_edge");

        // Asynchronous reset between clock edges.
        chk_px(516, 150, C0, 3'd2, "pre_async_reset");
        w = 0;
        while (sb.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries outstanding, expected 0", sb.size());
        end
        #1 rst = 1'b0;
        #1 check("async_reset_no_edge", act(), RST_VEC);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
